// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard controller for a 5-stage in-order core.
//
// Resolves three hazard sources, in priority order:
//   1. data memory busy      -> freeze the whole front end (no bubble)
//   2. taken branch/jump     -> flush IF/ID and bubble ID/EX
//   3. load-use dependency   -> hold PC and IF/ID for one cycle, bubble ID/EX
// The stall/flush outputs are combinational so they act in the same cycle.
// A memory-wait watchdog raises a sticky mem_timeout once the memory has been
// busy for TIMEOUT_CYC consecutive cycles.
//
// Parameters:
//   TIMEOUT_CYC          busy cycles before mem_timeout sets (1..511)
//
// Ports:
//   clk                  in   clock, rising edge
//   rst_n                in   asynchronous active-low reset
//   rs1_from_id          in   [4:0] ID-stage source register 1
//   rs2_from_id          in   [4:0] ID-stage source register 2
//   rd_to_ex             in   [4:0] destination register held in ID/EX
//   read_mem_to_ex       in   ID/EX holds a load
//   mem_busy             in   data memory not ready
//   branch_taken_from_ex in   EX resolved a taken branch/jump
//   pc_stall             out  hold PC
//   if_id_stall          out  hold IF/ID and ID/EX contents
//   id_stall_req         out  force ID/EX control fields to bubble
//   if_id_flush          out  clear IF/ID to NOP
//   mem_timeout          out  sticky memory-wait timeout flag
//   stall_cnt            out  [31:0] cycles with pc_stall=1
//                             (only when HAZARD_STALL_CNT_EN is defined)
//
// Build option:
//   HAZARD_STALL_CNT_EN  adds the stall_cnt port and its wrapping 32-bit counter.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_from_id,
  input  logic [4:0]  rs2_from_id,
  input  logic [4:0]  rd_to_ex,
  input  logic        read_mem_to_ex,
  input  logic        mem_busy,
  input  logic        branch_taken_from_ex,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_stall_req,
  output logic        if_id_flush,
  output logic        mem_timeout
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [8:0] TIMEOUT_VAL = 9'(TIMEOUT_CYC);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t     state;
  logic [8:0] wait_cnt;
  logic [8:0] wait_nxt;
  logic       load_use;

  // Load-use detection and prioritised stall/flush decode.
  always_comb begin
    load_use = read_mem_to_ex & (rd_to_ex != 5'd0) &
               ((rd_to_ex == rs1_from_id) | (rd_to_ex == rs2_from_id));
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_stall_req = 1'b0;
    if_id_flush  = 1'b0;
    if (mem_busy) begin
      // Freeze everything; inserting a bubble here would lose the ID/EX instr.
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
    end else if (branch_taken_from_ex) begin
      // Wrong-path instructions in IF/ID and ID are killed; load_use is moot.
      if_id_flush  = 1'b1;
      id_stall_req = 1'b1;
    end else if (load_use) begin
      // One-cycle stall; the bubble it creates removes the load from ID/EX,
      // so load_use drops by itself next cycle.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_stall_req = 1'b1;
    end else begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_stall_req = 1'b0;
      if_id_flush  = 1'b0;
    end
  end

  // Next value of the memory-wait counter. The edge that moves RUN->MEM_WAIT
  // already counts as the first wait cycle, so the counter equals the number
  // of consecutive busy cycles and hits TIMEOUT_VAL after exactly that many.
  always_comb begin
    wait_nxt = wait_cnt;
    if (mem_busy) begin
      if (wait_cnt != TIMEOUT_VAL) begin
        wait_nxt = wait_cnt + 9'd1;
      end else begin
        wait_nxt = wait_cnt;
      end
    end else if (state == MEM_WAIT) begin
      wait_nxt = 9'd0;
    end else begin
      wait_nxt = wait_cnt;
    end
  end

  // Memory-wait FSM, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= 9'd0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN:      state <= mem_busy ? MEM_WAIT : RUN;
        MEM_WAIT: state <= mem_busy ? MEM_WAIT : RUN;
        default:  state <= RUN;
      endcase
      wait_cnt <= wait_nxt;
      if (wait_nxt == TIMEOUT_VAL) begin
        mem_timeout <= 1'b1;
      end
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  // Performance counter of PC-stall cycles; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
    end else if (pc_stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl -- scoreboard bench for hazard_ctrl.
// A driver applies one input vector per cycle shortly after the rising edge,
// predicts the response from a behavioural model and pushes it into a queue;
// a monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int TMO = 256;

  typedef struct {
    logic       rst_n;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       ld;
    logic       busy;
    logic       br;
  } vec_t;

  typedef struct {
    logic        pc_stall;
    logic        if_id_stall;
    logic        id_stall_req;
    logic        if_id_flush;
    logic        mem_timeout;
    logic [31:0] stall_cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_from_id;
  logic [4:0]  rs2_from_id;
  logic [4:0]  rd_to_ex;
  logic        read_mem_to_ex;
  logic        mem_busy;
  logic        branch_taken_from_ex;
  logic        pc_stall;
  logic        if_id_stall;
  logic        id_stall_req;
  logic        if_id_flush;
  logic        mem_timeout;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .rs1_from_id          (rs1_from_id),
    .rs2_from_id          (rs2_from_id),
    .rd_to_ex             (rd_to_ex),
    .read_mem_to_ex       (read_mem_to_ex),
    .mem_busy             (mem_busy),
    .branch_taken_from_ex (branch_taken_from_ex),
    .pc_stall             (pc_stall),
    .if_id_stall          (if_id_stall),
    .id_stall_req         (id_stall_req),
    .if_id_flush          (if_id_flush),
    .mem_timeout          (mem_timeout)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cnt            (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: length of the current busy streak, sticky
  // timeout, and number of stalled edges since reset.
  int          busy_run;
  logic        m_timeout;
  logic [31:0] m_stalls;
  vec_t        cur;
  exp_t        sb[$];
  int          vectors;
  int          miscompares;
  int          busy_left;

  // Hazard rules stated directly: memory freeze beats branch flush beats load-use.
  function automatic exp_t predict(vec_t v);
    exp_t e;
    bit   lu;
    lu = v.ld && (v.rd != 5'd0) && (v.rd == v.rs1 || v.rd == v.rs2);
    e.pc_stall     = v.busy || (!v.br && lu);
    e.if_id_stall  = e.pc_stall;
    e.id_stall_req = !v.busy && (v.br || lu);
    e.if_id_flush  = !v.busy && v.br;
    e.mem_timeout  = m_timeout;
    e.stall_cnt    = m_stalls;
    return e;
  endfunction

  // Advance the model across a rising edge using the inputs seen at that edge.
  task automatic model_edge();
    exp_t e;
    if (cur.rst_n) begin
      e = predict(cur);
      if (e.pc_stall) m_stalls = m_stalls + 32'd1;
      if (cur.busy) busy_run = busy_run + 1;
      else busy_run = 0;
      if (busy_run >= TMO) m_timeout = 1'b1;
    end
  endtask

  task automatic apply(vec_t v);
    @(posedge clk);
    model_edge();
    #1;
    rst_n                = v.rst_n;
    rs1_from_id          = v.rs1;
    rs2_from_id          = v.rs2;
    rd_to_ex             = v.rd;
    read_mem_to_ex       = v.ld;
    mem_busy             = v.busy;
    branch_taken_from_ex = v.br;
    cur = v;
    if (!v.rst_n) begin
      busy_run  = 0;
      m_timeout = 1'b0;
      m_stalls  = 32'd0;
    end
    sb.push_back(predict(v));
  endtask

  function automatic vec_t mk(logic r, logic [4:0] a, logic [4:0] b, logic [4:0] d,
                              logic ld, logic busy, logic br);
    vec_t v;
    v.rst_n = r; v.rs1 = a; v.rs2 = b; v.rd = d;
    v.ld = ld; v.busy = busy; v.br = br;
    return v;
  endfunction

  // Monitor: compare every presented vector against its prediction.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (pc_stall !== e.pc_stall) begin
        miscompares++;
        $display("FAIL pc_stall @%0t: got %b want %b", $time, pc_stall, e.pc_stall);
      end
      if (if_id_stall !== e.if_id_stall) begin
        miscompares++;
        $display("FAIL if_id_stall @%0t: got %b want %b", $time, if_id_stall, e.if_id_stall);
      end
      if (id_stall_req !== e.id_stall_req) begin
        miscompares++;
        $display("FAIL id_stall_req @%0t: got %b want %b", $time, id_stall_req, e.id_stall_req);
      end
      if (if_id_flush !== e.if_id_flush) begin
        miscompares++;
        $display("FAIL if_id_flush @%0t: got %b want %b", $time, if_id_flush, e.if_id_flush);
      end
      if (mem_timeout !== e.mem_timeout) begin
        miscompares++;
        $display("FAIL mem_timeout @%0t: got %b want %b", $time, mem_timeout, e.mem_timeout);
      end
`ifdef HAZARD_STALL_CNT_EN
      if (stall_cnt !== e.stall_cnt) begin
        miscompares++;
        $display("FAIL stall_cnt @%0t: got %0d want %0d", $time, stall_cnt, e.stall_cnt);
      end
`endif
    end
  end

  initial begin
    vec_t v;
    vectors = 0; miscompares = 0; busy_left = 0;
    busy_run = 0; m_timeout = 1'b0; m_stalls = 32'd0;
    rst_n = 1'b0; rs1_from_id = 5'd0; rs2_from_id = 5'd0; rd_to_ex = 5'd0;
    read_mem_to_ex = 1'b0; mem_busy = 1'b0; branch_taken_from_ex = 1'b0;
    cur = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Reset state, and outputs following inputs while in reset.
    apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
    apply(mk(1'b0, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0));
    apply(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));

    // Load-use on rs2, then the bubble.
    apply(mk(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0));
    apply(mk(1'b1, 5'd1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0));
    // rd = x0 never stalls.
    apply(mk(1'b1, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0));
    // Branch concurrent with load-use.
    apply(mk(1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1));
    // Load-use on rs1, no branch.
    apply(mk(1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0));

    // Ten busy cycles with a pending branch, then the flush.
    for (int i = 0; i < 10; i++) apply(mk(1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1));
    apply(mk(1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 1'b0, 1'b1));
    apply(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));

    // 300-cycle memory wait: timeout appears after 256 busy cycles and sticks.
    for (int i = 0; i < 300; i++) apply(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 5; i++) apply(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
    apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
    apply(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));

    // Reset mid-wait, then a near-threshold wait that must not time out.
    for (int i = 0; i < 200; i++) apply(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0));
    apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 255; i++) apply(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0));
    apply(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
    apply(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));

    // Three load-use stalls plus ten busy cycles from a fresh reset.
    apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      apply(mk(1'b1, 5'd6, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0));
      apply(mk(1'b1, 5'd6, 5'd1, 5'd6, 1'b0, 1'b0, 1'b0));
    end
    for (int i = 0; i < 10; i++) apply(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0));
    apply(mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0));

    // Randomised traffic with small register numbers to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      if (busy_left == 0 && $urandom_range(0, 15) == 0) busy_left = $urandom_range(1, 20);
      v.rst_n = ($urandom_range(0, 299) != 0);
      v.rs1   = 5'($urandom_range(0, 3));
      v.rs2   = 5'($urandom_range(0, 3));
      v.rd    = 5'($urandom_range(0, 3));
      v.ld    = 1'($urandom_range(0, 1));
      v.br    = ($urandom_range(0, 5) == 0);
      v.busy  = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      apply(v);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL: parameter TIMEOUT_CYC, default 256, mem_busy cycles before mem_timeout asserts.
REQ-002 SHALL: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL: rs1_from_id  in  5  ID-stage source register 1.
REQ-005 SHALL: rs2_from_id  in  5  ID-stage source register 2.
REQ-006 SHALL: rd_to_ex  in  5  destination register held in ID/EX.
REQ-007 SHALL: read_mem_to_ex  in  1  ID/EX holds a load.
REQ-008 SHALL: mem_busy  in  1  data memory not ready, whole pipe must freeze.
REQ-009 SHALL: branch_taken_from_ex  in  1  EX resolved a taken branch/jump.
REQ-010 SHALL: pc_stall  out  1  hold PC.
REQ-011 SHALL: if_id_stall  out  1  hold IF/ID and ID/EX contents.
REQ-012 SHALL: id_stall_req  out  1  force ID/EX control fields to bubble.
REQ-013 SHALL: if_id_flush  out  1  clear IF/ID to NOP.
REQ-014 SHALL: mem_timeout  out  1  sticky flag, memory wait exceeded TIMEOUT_CYC.
REQ-015 SHALL: stall_cnt  out  32  cycles with pc_stall=1 (present only with STALL_CNT_EN).

Function
REQ-016 SHALL: load_use = read_mem_to_ex & (rd_to_ex!=0) & (rd_to_ex==rs1_from_id | rd_to_ex==rs2_from_id).
REQ-017 SHALL: FSM states RUN, MEM_WAIT; RUN->MEM_WAIT when mem_busy=1 at an edge; MEM_WAIT->RUN when mem_busy=0 at an edge.
REQ-018 SHALL: outputs are combinational from inputs (same-cycle, zero latency); priority mem_busy > branch_taken_from_ex > load_use.
REQ-019 SHALL: mem_busy=1 -> pc_stall=1, if_id_stall=1, id_stall_req=0, if_id_flush=0 (freeze, no bubble).
REQ-020 SHALL: mem_busy=0 & branch_taken_from_ex=1 -> if_id_flush=1, id_stall_req=1, pc_stall=0, if_id_stall=0; load_use ignored that cycle.
REQ-021 SHALL: mem_busy=0 & branch=0 & load_use=1 -> pc_stall=1, if_id_stall=1, id_stall_req=1 for exactly that cycle; the following cycle ID/EX holds a bubble, so load_use deasserts without extra state.
REQ-022 SHALL: no condition active -> all four stall/flush outputs 0.
REQ-023 SHALL: 9-bit wait counter increments each cycle in MEM_WAIT with mem_busy=1, saturating at TIMEOUT_CYC; clears on MEM_WAIT->RUN.
REQ-024 SHALL: mem_timeout sets on the edge where wait counter reaches TIMEOUT_CYC; stays 1 until reset, even after mem_busy falls.
REQ-025 SHALL: timeout does not alter stall outputs; pipeline stays frozen while mem_busy=1.
REQ-026 SHALL: rd_to_ex=0 never triggers load_use, regardless of rs1/rs2.

Reset
REQ-027 SHALL: rst_n=0 asynchronously forces state RUN, wait counter 0, mem_timeout 0, stall_cnt 0.
REQ-028 SHALL: reset asserted mid-MEM_WAIT abandons the wait; after release, FSM evaluates mem_busy fresh from RUN.
REQ-029 SHALL: combinational outputs follow inputs during reset except mem_timeout/stall_cnt, which read 0.

Configuration
REQ-030 SHALL: macro HAZARD_STALL_CNT_EN defined -> stall_cnt port and 32-bit counter present, incrementing each edge with pc_stall=1, wrapping 0xFFFFFFFF->0.
REQ-031 SHALL: macro undefined -> stall_cnt port and counter absent; all other behaviour identical.

Verification
REQ-032 SHALL: read_mem_to_ex=1, rd_to_ex=5, rs2_from_id=5 -> pc_stall=if_id_stall=id_stall_req=1 one cycle; bubble next cycle -> all 0.
REQ-033 SHALL: same load with rd_to_ex=0, rs1_from_id=0 -> no stall.
REQ-034 SHALL: branch_taken_from_ex=1 concurrent with load_use -> if_id_flush=1, id_stall_req=1, pc_stall=0.
REQ-035 SHALL: mem_busy=1 for 10 cycles with branch=1 -> freeze all 10 cycles, no flush; flush on cycle 11 when mem_busy=0.
REQ-036 SHALL: mem_busy=1 for 300 cycles -> mem_timeout rises at cycle 256, remains 1 after mem_busy=0 until rst_n pulse.
REQ-037 SHALL: with HAZARD_STALL_CNT_EN, 3 load-use stalls + 10 busy cycles -> stall_cnt=13; rst_n pulse -> 0.
